// File: rtl/vga_timing_pixel_out.sv
// vga_timing_pixel_out: 640x480@60 VGA raster timing plus registered pixel output stage.
// Raster counters advance once per pixel period (CLK_DIV system clocks). Colour, sync
// and blank are all registered from the same pre-advance counter values, giving one pixel
// of latency with everything mutually aligned.
// Optional macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces rgb_in with
// eight 80-pixel-wide colour bars.
module vga_timing_pixel_out #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        pix_en,
    output logic [9:0]  screen_x,
    output logic [9:0]  screen_y,
    output logic        active_area,
    output logic        frame_start,
    output logic [9:0]  vga_r,
    output logic [9:0]  vga_g,
    output logic [9:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic [3:0]  div_cnt;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        h_last;
    logic        v_last;
    logic        hs_pulse;
    logic        vs_pulse;
    logic [29:0] pix_rgb;

    // Pixel-rate divider; pix_en is registered so it stays low through reset and the
    // first pulse lands CLK_DIV clocks after release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
        end
    end

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Raster counters: H advances per pixel, V advances on each H wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign screen_x    = h_cnt;
    assign screen_y    = v_cnt;
    assign active_area = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    assign frame_start = pix_en && h_last && v_last;
    assign hs_pulse    = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END));
    assign vs_pulse    = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END));
    assign vga_sync_n  = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    assign bar_idx = 3'(h_cnt / 10'd80);

    // Pixel colour source: colour bars in test mode, game logic otherwise.
    always_comb begin
        pix_rgb = rgb_in;
        if (test_mode)
            pix_rgb = {{10{bar_idx[2]}}, {10{bar_idx[1]}}, {10{bar_idx[0]}}};
    end
`else
    assign pix_rgb = rgb_in;
`endif

    // DAC/pin stage: capture colour, sync and blank for the current pixel together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            vga_r       <= active_area ? pix_rgb[29:20] : 10'd0;
            vga_g       <= active_area ? pix_rgb[19:10] : 10'd0;
            vga_b       <= active_area ? pix_rgb[9:0]   : 10'd0;
            vga_hs      <= ~hs_pulse;
            vga_vs      <= ~vs_pulse;
            vga_blank_n <= active_area;
        end
    end

endmodule

// File: tb/tb_vga_timing_pixel_out.sv
// Bench for vga_timing_pixel_out using a shrunken raster (30x15 total) so full frames
// fit in a short run. Expected outputs are derived from the number of clocks since
// reset release with plain arithmetic.
module tb_vga_timing_pixel_out;

    localparam int D   = 2;
    localparam int HV  = 16, HFP = 4, HS = 6, HBP = 4;
    localparam int VV  = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] rgb_in;
    logic        pix_en, active_area, frame_start;
    logic [9:0]  screen_x, screen_y, vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    logic [29:0] seed = 30'h1234567;
    logic        all_ones = 1'b0;
    int          t = 0;
    int          checks = 0;
    int          errors = 0;
    logic [56:0] obs;
    logic [56:0] ev;

    always #5 clk = ~clk;

    vga_timing_pixel_out #(
        .CLK_DIV(D), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pix_en(pix_en), .screen_x(screen_x), .screen_y(screen_y),
        .active_area(active_area), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n)
    );

    // Game-logic stand-in: colour is a pure function of the raster position.
    function automatic logic [29:0] rgb_of(int x, int y, logic [29:0] sd, logic ao);
        if (ao) return 30'h3FFFFFFF;
        return {10'(x * 7) ^ sd[29:20], 10'(y * 13) ^ sd[19:10], 10'(x + y) ^ sd[9:0]};
    endfunction

    assign rgb_in = rgb_of(int'(screen_x), int'(screen_y), seed, all_ones);
    assign obs = {pix_en, screen_x, screen_y, active_area, frame_start,
                  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n};

    // Reference: everything follows from tc = clocks since reset release.
    function automatic logic [56:0] exp_vec(int tc, logic [29:0] sd, logic ao);
        int p, x, y, q, qx, qy;
        logic pe, act, fs, hs, vs, bn;
        logic [29:0] c;
        pe  = (tc > 0) && (tc % D == 0);
        p   = (tc == 0) ? 0 : (tc - 1) / D;
        x   = p % HT;
        y   = (p / HT) % VT;
        act = (x < HV) && (y < VV);
        fs  = pe && (x == HT - 1) && (y == VT - 1);
        if (p == 0) begin
            c = '0; hs = 1'b1; vs = 1'b1; bn = 1'b0;
        end else begin
            q  = p - 1;
            qx = q % HT;
            qy = (q / HT) % VT;
            bn = (qx < HV) && (qy < VV);
            hs = !((qx >= HV + HFP) && (qx < HV + HFP + HS));
            vs = !((qy >= VV + VFP) && (qy < VV + VFP + VS));
            c  = bn ? rgb_of(qx, qy, sd, ao) : 30'd0;
        end
        return {pe, 10'(x), 10'(y), act, fs, c, hs, vs, bn, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        t = reset_n ? t + 1 : 0;
        @(negedge clk);
        ev = exp_vec(t, seed, all_ones);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) begin
            tick();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL reset_hold t=%0d got %h exp %h", t, obs, ev);
            end
        end
        reset_n = 1'b1;
        repeat (12) begin
            tick();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL reset_release t=%0d got %h exp %h", t, obs, ev);
            end
        end
    endtask

    task automatic test_line();
        int npix = 0, hs_low = 0;
        repeat (HT * D) begin
            tick();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL line t=%0d got %h exp %h", t, obs, ev);
            end
            if (pix_en === 1'b1) begin
                npix++;
                if (vga_hs === 1'b0) hs_low++;
            end
        end
        checks++;
        if (npix !== HT || hs_low !== HS) begin
            errors++;
            $display("FAIL line_hs_width pix=%0d hs_low=%0d exp pix=%0d hs_low=%0d", npix, hs_low, HT, HS);
        end
    endtask

    task automatic test_frame();
        int fs = 0, vs_low = 0, vis = 0;
        repeat (HT * VT * D) begin
            tick();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL frame t=%0d got %h exp %h", t, obs, ev);
            end
            if (frame_start === 1'b1) fs++;
            if (pix_en === 1'b1) begin
                if (vga_vs === 1'b0) vs_low++;
                if (vga_blank_n === 1'b1) vis++;
            end
        end
        checks++;
        if (fs !== 1 || vs_low !== VS * HT || vis !== HV * VV) begin
            errors++;
            $display("FAIL frame_counts fs=%0d vs_low=%0d vis=%0d exp 1 %0d %0d",
                     fs, vs_low, vis, VS * HT, HV * VV);
        end
    endtask

    task automatic test_edge_colour();
        reset_n = 1'b0;
        tick();
        all_ones = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (HT * D * 3) begin
            tick();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL edge_colour t=%0d got %h exp %h", t, obs, ev);
            end
            if (pix_en === 1'b1 && screen_y < VV && screen_x == HV) begin
                checks++;
                if (vga_r !== 10'h3FF || vga_blank_n !== 1'b1) begin
                    errors++;
                    $display("FAIL last_visible r=%h bn=%b exp 3ff 1", vga_r, vga_blank_n);
                end
            end
            if (pix_en === 1'b1 && screen_y < VV && screen_x == HV + 1) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 30'd0 || vga_blank_n !== 1'b0) begin
                    errors++;
                    $display("FAIL first_blank rgb=%h bn=%b exp 0 0", {vga_r, vga_g, vga_b}, vga_blank_n);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        bit found = 0;
        while (!found && n < HT * VT * D + 10) begin
            tick();
            n++;
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL mid_reset_run t=%0d got %h exp %h", t, obs, ev);
            end
            if (screen_x == 10 && screen_y == 5) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_wait got timeout exp x=10 y=5");
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (screen_x !== 10'd0 || screen_y !== 10'd0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 ||
            {vga_r, vga_g, vga_b} !== 30'd0 || pix_en !== 1'b0 || vga_blank_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got x=%0d y=%0d hs=%b vs=%b rgb=%h exp 0 0 1 1 0",
                     screen_x, screen_y, vga_hs, vga_vs, {vga_r, vga_g, vga_b});
        end
        reset_n = 1'b1;
        repeat (40) begin
            tick();
            checks++;
            if (obs !== ev) begin
                errors++;
                $display("FAIL mid_reset_restart t=%0d got %h exp %h", t, obs, ev);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            reset_n = 1'b0;
            tick();
            seed = 30'($urandom);
            all_ones = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) tick();
            reset_n = 1'b1;
            repeat ($urandom_range(50, 1200)) begin
                tick();
                checks++;
                if (obs !== ev) begin
                    errors++;
                    $display("FAIL random it=%0d t=%0d got %h exp %h", it, t, obs, ev);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_edge_colour();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
